// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer: FSM state encoding,
// length-field sizing and the length clamp applied to incoming words.
package bit_serializer_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_LEN_W  = $clog2(DEFAULT_DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SHIFT
    } state_t;

    // Width needed to hold any length from 0 up to data_w inclusive.
    function automatic int len_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

    function automatic int clamp_len(input int len, input int data_w);
        return (len > data_w) ? data_w : len;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Serializes variable-length words MSB first with a per-bit valid, a last-bit
// flag and an optional one-cycle clear request ahead of each word.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LEN_W  = len_width(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              in_clear,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              ser_clear,
    output logic              ser_last,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_c;
    logic              last_bit;
    logic              accept;
    logic              bit_d, valid_d, clear_d, last_d, busy_d;

    assign last_bit = (state_q == SHIFT) && (idx_q == '0);
    assign in_ready = !reset && ((state_q == IDLE) || last_bit);
    assign accept   = in_valid && in_ready;
    assign len_c    = LEN_W'(clamp_len(int'(in_len), DATA_W));

    // While in CLEAR, idx_q holds the full captured length rather than a bit index.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            IDLE, SHIFT: begin
                if (accept) begin
                    data_d = in_data;
                    if (in_clear) begin
                        state_d = CLEAR;
                        idx_d   = len_c;
                    end else if (len_c != '0) begin
                        state_d = SHIFT;
                        idx_d   = len_c - LEN_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (state_q == SHIFT) begin
                    if (idx_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q - LEN_W'(1);
                    end
                end
            end
            CLEAR: begin
                if (idx_q == '0) begin
                    state_d = IDLE;
                end else begin
                    state_d = SHIFT;
                    idx_d   = idx_q - LEN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered with it.
    always_comb begin
        bit_d   = ser_bit;
        valid_d = 1'b0;
        clear_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = (state_d != IDLE);
        case (state_d)
            SHIFT: begin
                valid_d = 1'b1;
                last_d  = (idx_d == '0);
                for (int i = 0; i < DATA_W; i++) begin
                    if (idx_d == LEN_W'(i)) begin
                        bit_d = data_d[i];
                    end
                end
            end
            CLEAR:   clear_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            ser_clear <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            ser_bit   <= bit_d;
            ser_valid <= valid_d;
            ser_clear <= clear_d;
            ser_last  <= last_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based output model.
module tb_bit_serializer;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [LEN_W-1:0]  in_len = '0;
    logic              in_clear = 1'b0;
    logic              ser_bit, ser_valid, ser_clear, ser_last, busy;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    bit_serializer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_len(in_len), .in_clear(in_clear),
        .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_clear(ser_clear),
        .ser_last(ser_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: every output cycle a word produces is queued at accept time.
    typedef struct packed {
        logic clr;
        logic b;
        logic last;
    } ev_t;

    ev_t pend[$];
    ev_t m_cur = '0;
    bit  m_act = 1'b0;

    function automatic bit modelReady();
        return !reset && (pend.size() == 0) && (!m_act || m_cur.last);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            pend.delete();
            m_act = 1'b0;
        end else begin
            if (in_valid && modelReady()) begin
                int len;
                len = (int'(in_len) > DATA_W) ? DATA_W : int'(in_len);
                if (in_clear) pend.push_back('{clr: 1'b1, b: 1'b0, last: 1'b0});
                for (int i = len - 1; i >= 0; i--)
                    pend.push_back('{clr: 1'b0, b: in_data[i], last: (i == 0)});
            end
            if (pend.size() > 0) begin
                m_cur = pend.pop_front();
                m_act = 1'b1;
            end else begin
                m_act = 1'b0;
            end
        end
    end

    // Consumer accumulating the serial stream as the divisibility checkers would.
    int cval  = 0;
    int nbits = 0;
    always @(negedge clk) begin
        if (ser_clear) begin
            cval  = 0;
            nbits = 0;
        end else if (ser_valid) begin
            cval  = (cval << 1) | int'(ser_bit);
            nbits = nbits + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("model_ctl", {27'b0, in_ready, ser_valid, ser_clear, ser_last, busy},
                        {27'b0, modelReady(), m_act && !m_cur.clr, m_act && m_cur.clr,
                         m_act && m_cur.last, m_act});
            if (m_act && !m_cur.clr)
                checkOutput("model_bit", {31'b0, ser_bit}, {31'b0, m_cur.b});
        end
    end

    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                                 input logic [LEN_W-1:0] l, input logic c);
        in_valid = v;
        in_data  = d;
        in_len   = l;
        in_clear = c;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus(0, '0, '0, 0);
        repeat (2) nextCycle();
        checkOutput("reset_state", {26'b0, in_ready, ser_bit, ser_valid, ser_clear, ser_last, busy}, 32'h0);
        checking = 1'b1;
        reset = 1'b0;
        #1;
        checkOutput("ready_after_reset", {31'b0, in_ready}, 32'h1);

        // 0xA len 4 with clear
        applyStimulus(1, 16'hA, 5'd4, 1);
        nextCycle();
        applyStimulus(0, '0, '0, 0);
        checkOutput("t1_clear", {30'b0, ser_clear, ser_valid}, 32'h2);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkOutput("t1_bit", {29'b0, ser_valid, ser_bit, ser_last},
                        {29'b0, 1'b1, (4'hA >> (3 - i)) & 4'h1 ? 1'b1 : 1'b0, (i == 3)});
            checkOutput("t1_ready", {31'b0, in_ready}, {31'b0, (i == 3)});
        end
        repeat (2) nextCycle();

        // Back-to-back: 0x3 len 2 clear, then 0x1 len 1 append
        applyStimulus(1, 16'h3, 5'd2, 1);
        nextCycle();
        applyStimulus(1, 16'h1, 5'd1, 0);
        nextCycle();
        checkOutput("t2_bit0", {30'b0, ser_valid, ser_bit}, 32'h3);
        nextCycle();
        checkOutput("t2_bit1", {28'b0, ser_valid, ser_bit, ser_last, in_ready}, 32'hF);
        nextCycle();
        applyStimulus(0, '0, '0, 0);
        checkOutput("t2_bit2", {29'b0, ser_valid, ser_bit, ser_last}, 32'h7);
        nextCycle();
        checkOutput("t2_gap_end", {31'b0, ser_valid}, 32'h0);
        nextCycle();
        checkOutput("t2_value", cval, 32'd7);

        // Zero-length words
        applyStimulus(1, 16'hF, 5'd0, 0);
        nextCycle();
        applyStimulus(0, '0, '0, 0);
        checkOutput("t3_len0", {28'b0, in_ready, ser_valid, ser_clear, busy}, 32'h8);
        applyStimulus(1, 16'hF, 5'd0, 1);
        nextCycle();
        applyStimulus(0, '0, '0, 0);
        checkOutput("t3_len0_clr", {28'b0, in_ready, ser_valid, ser_clear, busy}, 32'h3);
        nextCycle();
        checkOutput("t3_len0_idle", {28'b0, in_ready, ser_valid, ser_clear, busy}, 32'h8);

        // Length clamp
        applyStimulus(1, 16'h8001, 5'd31, 1);
        nextCycle();
        applyStimulus(0, '0, '0, 0);
        repeat (17) nextCycle();
        checkOutput("t4_value", cval, 32'h8001);
        checkOutput("t4_nbits", nbits, 32'd16);

        // Reset on the third bit of a 16-bit word
        applyStimulus(1, 16'hBEEF, 5'd16, 0);
        nextCycle();
        applyStimulus(0, '0, '0, 0);
        repeat (2) nextCycle();
        reset = 1'b1;
        #1;
        checkOutput("t5_ready_in_reset", {31'b0, in_ready}, 32'h0);
        nextCycle();
        reset = 1'b0;
        #1;
        checkOutput("t5_after_reset", {26'b0, in_ready, ser_bit, ser_valid, ser_clear, ser_last, busy}, 32'h20);
        applyStimulus(1, 16'h5, 5'd3, 1);
        nextCycle();
        applyStimulus(0, '0, '0, 0);
        repeat (5) nextCycle();
        checkOutput("t5_next_word", cval, 32'd5);

        // Valid held while busy; data changes before/after accept
        applyStimulus(1, 16'hFF, 5'd4, 1);
        nextCycle();
        applyStimulus(1, 16'h0, 5'd4, 0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput("t6_stall", {31'b0, in_ready}, 32'h0);
        end
        nextCycle();
        checkOutput("t6_ready_last", {31'b0, in_ready}, 32'h1);
        applyStimulus(1, 16'h9, 5'd4, 0);
        nextCycle();
        applyStimulus(0, 16'h6, 5'd4, 0);
        repeat (5) nextCycle();
        checkOutput("t6_value", cval, 32'hF9);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 60) == 0);
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 5'($urandom_range(0, 20)),
                          ($urandom_range(0, 3) == 0));
            nextCycle();
        end
        reset = 1'b0;
        applyStimulus(0, '0, '0, 0);
        repeat (25) nextCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
